// File: rtl/bomb_countdown_timer.sv
// BCD MM:SS.cc countdown timer with pause, time penalties, defuse and expiry flag.
// Optional TIMER_BEEP_EN adds a 'beep' pulse output for the final ten seconds and for expiry.
module bomb_countdown_timer #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned TICK_HZ     = 100,
  parameter int unsigned START_MIN   = 5,
  parameter int unsigned START_SEC   = 0,
  parameter int unsigned PENALTY_SEC = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic       penalty,
  input  logic       defuse,
  output logic [3:0] time_left_minute_tens,
  output logic [3:0] time_left_minute_ones,
  output logic [3:0] time_left_sec_tens,
  output logic [3:0] time_left_sec_ones,
  output logic [3:0] time_left_micro_sec_tens,
  output logic [3:0] time_left_micro_sec_ones,
`ifdef TIMER_BEEP_EN
  output logic       beep,
`endif
  output logic       running,
  output logic       expired
);

  localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
  localparam int unsigned PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [5:0]  PEN_CNT = 6'(PENALTY_SEC);

  localparam logic [3:0] RL_MT = 4'(START_MIN / 10);
  localparam logic [3:0] RL_MO = 4'(START_MIN % 10);
  localparam logic [3:0] RL_ST = 4'(START_SEC / 10);
  localparam logic [3:0] RL_SO = 4'(START_SEC % 10);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUNNING = 3'd1,
    S_PAUSED  = 3'd2,
    S_PENALTY = 3'd3,
    S_EXPIRED = 3'd4,
    S_DEFUSED = 3'd5
  } state_t;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
    logic [3:0] ht;
    logic [3:0] ho;
  } bcd_time_t;

  localparam bcd_time_t RELOAD = {RL_MT, RL_MO, RL_ST, RL_SO, 4'd0, 4'd0};

  // One BCD digit step: {borrow_out, digit}. Out-of-range codes collapse to max_d.
  function automatic logic [4:0] dec_digit(input logic [3:0] d, input logic [3:0] max_d,
                                           input logic b);
    logic [4:0] r;
    if (!b) begin
      r = {1'b0, d};
    end else if (d == 4'd0) begin
      r = {1'b1, max_d};
    end else if (d > max_d) begin
      r = {1'b0, max_d};
    end else begin
      r = {1'b0, d - 4'd1};
    end
    return r;
  endfunction

  function automatic logic [3:0] dec_top(input logic [3:0] d, input logic b);
    logic [3:0] r;
    if (b && (d != 4'd0)) begin
      r = (d > 4'd9) ? 4'd9 : d - 4'd1;
    end else begin
      r = (d > 4'd9) ? 4'd9 : d;
    end
    return r;
  endfunction

  function automatic bcd_time_t sub_hundredth(input bcd_time_t t);
    bcd_time_t  r;
    logic [4:0] s;
    s    = dec_digit(t.ho, 4'd9, 1'b1);
    r.ho = s[3:0];
    s    = dec_digit(t.ht, 4'd9, s[4]);
    r.ht = s[3:0];
    s    = dec_digit(t.so, 4'd9, s[4]);
    r.so = s[3:0];
    s    = dec_digit(t.st, 4'd5, s[4]);
    r.st = s[3:0];
    s    = dec_digit(t.mo, 4'd9, s[4]);
    r.mo = s[3:0];
    r.mt = dec_top(t.mt, s[4]);
    return r;
  endfunction

  function automatic bcd_time_t sub_second(input bcd_time_t t);
    bcd_time_t  r;
    logic [4:0] s;
    r.ho = t.ho;
    r.ht = t.ht;
    s    = dec_digit(t.so, 4'd9, 1'b1);
    r.so = s[3:0];
    s    = dec_digit(t.st, 4'd5, s[4]);
    r.st = s[3:0];
    s    = dec_digit(t.mo, 4'd9, s[4]);
    r.mo = s[3:0];
    r.mt = dec_top(t.mt, s[4]);
    return r;
  endfunction

  function automatic logic mmss_zero(input bcd_time_t t);
    return (t.mt == 4'd0) && (t.mo == 4'd0) && (t.st == 4'd0) && (t.so == 4'd0);
  endfunction

  state_t      state_q, state_d;
  bcd_time_t   time_q, time_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        origin_run_q, origin_run_d;
  logic        running_q, running_d;
  logic        expired_q, expired_d;
  logic        tick_s;
  bcd_time_t   dec_s;
  bcd_time_t   sec_s;
`ifdef TIMER_BEEP_EN
  logic        beep_q, beep_d;
`endif

  assign tick_s = (state_q == S_RUNNING) && (pre_q == PRE_MAX);
  assign dec_s  = sub_hundredth(time_q);
  assign sec_s  = sub_second(time_q);

  // Next-state, time and prescaler; events resolved load > defuse > penalty > pause > start > tick.
  always_comb begin
    state_d      = state_q;
    time_d       = time_q;
    cnt_d        = cnt_q;
    origin_run_d = origin_run_q;
`ifdef TIMER_BEEP_EN
    beep_d       = 1'b0;
`endif
    if (state_q == S_RUNNING) begin
      pre_d = tick_s ? '0 : pre_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      pre_d = pre_q;
    end

    if (load) begin
      state_d = S_IDLE;
      time_d  = RELOAD;
      pre_d   = '0;
      cnt_d   = 6'd0;
    end else if (defuse && ((state_q == S_RUNNING) || (state_q == S_PAUSED) ||
                            (state_q == S_PENALTY))) begin
      state_d = S_DEFUSED;
      pre_d   = '0;
      cnt_d   = 6'd0;
    end else if (penalty && ((state_q == S_RUNNING) || (state_q == S_PAUSED))) begin
      state_d      = S_PENALTY;
      cnt_d        = PEN_CNT;
      origin_run_d = (state_q == S_RUNNING);
    end else if (pause && (state_q == S_RUNNING)) begin
      state_d = S_PAUSED;
      pre_d   = '0;
    end else if (start && ((state_q == S_IDLE) || (state_q == S_PAUSED))) begin
      state_d = S_RUNNING;
    end else if (state_q == S_PENALTY) begin
      // Clamp to 00:00.00 when the penalty cannot be fully paid.
      if (mmss_zero(time_q)) begin
        time_d.ht = 4'd0;
        time_d.ho = 4'd0;
        state_d   = S_EXPIRED;
        cnt_d     = 6'd0;
      end else if (mmss_zero(sec_s) &&
                   ((cnt_q > 6'd1) || ((sec_s.ht == 4'd0) && (sec_s.ho == 4'd0)))) begin
        time_d    = sec_s;
        time_d.ht = 4'd0;
        time_d.ho = 4'd0;
        state_d   = S_EXPIRED;
        cnt_d     = 6'd0;
      end else if (cnt_q <= 6'd1) begin
        time_d  = sec_s;
        cnt_d   = 6'd0;
        state_d = origin_run_q ? S_RUNNING : S_PAUSED;
      end else begin
        time_d = sec_s;
        cnt_d  = cnt_q - 6'd1;
      end
    end else if (tick_s) begin
      time_d = dec_s;
      if (mmss_zero(dec_s) && (dec_s.ht == 4'd0) && (dec_s.ho == 4'd0)) begin
        state_d = S_EXPIRED;
      end else begin
        state_d = S_RUNNING;
      end
`ifdef TIMER_BEEP_EN
      if ((dec_s.so != time_q.so) && (dec_s.mt == 4'd0) && (dec_s.mo == 4'd0) &&
          (dec_s.st == 4'd0)) begin
        beep_d = 1'b1;
      end else begin
        beep_d = 1'b0;
      end
`endif
    end else begin
      time_d = time_q;
    end

`ifdef TIMER_BEEP_EN
    if ((state_d == S_EXPIRED) && (state_q != S_EXPIRED)) begin
      beep_d = 1'b1;
    end else begin
      beep_d = beep_d;
    end
`endif

    case (state_d)
      S_RUNNING, S_PENALTY: begin
        running_d = 1'b1;
        expired_d = 1'b0;
      end
      S_EXPIRED: begin
        running_d = 1'b0;
        expired_d = 1'b1;
      end
      default: begin
        running_d = 1'b0;
        expired_d = 1'b0;
      end
    endcase
  end

  // State, time digits, prescaler and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      time_q       <= RELOAD;
      pre_q        <= '0;
      cnt_q        <= 6'd0;
      origin_run_q <= 1'b0;
      running_q    <= 1'b0;
      expired_q    <= 1'b0;
`ifdef TIMER_BEEP_EN
      beep_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      time_q       <= time_d;
      pre_q        <= pre_d;
      cnt_q        <= cnt_d;
      origin_run_q <= origin_run_d;
      running_q    <= running_d;
      expired_q    <= expired_d;
`ifdef TIMER_BEEP_EN
      beep_q       <= beep_d;
`endif
    end
  end

  assign time_left_minute_tens    = time_q.mt;
  assign time_left_minute_ones    = time_q.mo;
  assign time_left_sec_tens       = time_q.st;
  assign time_left_sec_ones       = time_q.so;
  assign time_left_micro_sec_tens = time_q.ht;
  assign time_left_micro_sec_ones = time_q.ho;
  assign running                  = running_q;
  assign expired                  = expired_q;
`ifdef TIMER_BEEP_EN
  assign beep                     = beep_q;
`endif

endmodule
